// File: rtl/rls_pkg.sv
// Shared definitions for the RLS result reader: FSM state encoding and the
// Q17.15 sample-format constants.
package rls_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } rls_state_e;

    localparam int unsigned FRAC_BITS = 15;
    localparam logic [31:0] ONE       = 32'h0000_8000;

endpackage

// File: rtl/rls_fifo_mem.sv
// Simple dual-port DEPTH x WIDTH sample store: one write port, one read port
// with a registered output (read-during-write to the same address returns old data).
module rls_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/rls_result_reader.sv
// Captures a run of Q17.15 samples into a circular FIFO and drains them to a
// valid/ready consumer. Optional min/max tracking is enabled by RLS_READER_MINMAX_EN.
//
// state   | meaning
// IDLE    | waiting for the first write or an immediate final
// CAPTURE | storing producer samples until final
// DRAIN   | writes ignored; emptying the buffer
// DONE    | buffer drained after final; held until reset
module rls_result_reader
    import rls_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   write,
    input  logic [WIDTH-1:0]       x,
    input  logic                   final_i,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   done
`ifdef RLS_READER_MINMAX_EN
    ,
    output logic signed [WIDTH-1:0] min_x,
    output logic signed [WIDTH-1:0] max_x
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    rls_state_e       state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] byp_q, byp_d;
    logic             byp_sel_q, byp_sel_d;
    logic [WIDTH-1:0] mem_rdata;

    logic full, pop, can_store, push;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (final_i) begin
                    state_d = DRAIN;
                end else if (write) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (final_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (count_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        full      = (count_q == FULL);
        pop       = (count_q != '0) && rd_ready;
        can_store = write && ((state_q == IDLE) || (state_q == CAPTURE));
        push      = can_store && (!full || pop);

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        ovf_d = ovf_q | (can_store && full && !pop);

        // The memory cannot return a sample written on the same edge it is read,
        // so a store landing on the next head address is forwarded through byp_q.
        byp_d     = byp_q;
        byp_sel_d = byp_sel_q && !pop;
        if (push) begin
            byp_sel_d = (wr_ptr_q == rd_ptr_d);
            if (wr_ptr_q == rd_ptr_d) begin
                byp_d = x;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            byp_q     <= '0;
            byp_sel_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            byp_q     <= byp_d;
            byp_sel_q <= byp_sel_d;
        end
    end

    rls_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (push && !reset),
        .waddr_i (wr_ptr_q),
        .wdata_i (x),
        .raddr_i (rd_ptr_d),
        .rdata_o (mem_rdata)
    );

    assign rd_valid = (count_q != '0);
    assign rd_data  = byp_sel_q ? byp_q : mem_rdata;
    assign count    = count_q;
    assign overflow = ovf_q;
    assign done     = (state_q == DONE);

`ifdef RLS_READER_MINMAX_EN
    logic signed [WIDTH-1:0] min_q, min_d;
    logic signed [WIDTH-1:0] max_q, max_d;
    logic                    seen_q, seen_d;

    always_comb begin
        min_d  = min_q;
        max_d  = max_q;
        seen_d = seen_q;
        if (push) begin
            seen_d = 1'b1;
            if (!seen_q || ($signed(x) < min_q)) begin
                min_d = $signed(x);
            end
            if (!seen_q || ($signed(x) > max_q)) begin
                max_d = $signed(x);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            min_q  <= '0;
            max_q  <= '0;
            seen_q <= 1'b0;
        end else begin
            min_q  <= min_d;
            max_q  <= max_d;
            seen_q <= seen_d;
        end
    end

    assign min_x = min_q;
    assign max_x = max_q;
`endif

endmodule
